// File: rtl/led595_pkg.sv
// Shared types and constants for the 74HC595 LED serializer.
package led595_pkg;

    typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LT_HI, LT_LO} state_t;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DIV      = 4;
    localparam int DEF_PWM_BITS = 4;

    // clk cycles from load acceptance to the end of the latch pulse
    function automatic int frame_cycles(input int width, input int div);
        return (2 * width + 2) * div;
    endfunction

endpackage

// File: rtl/led595_serializer_if.sv
// Pattern request / 595 pin bundle for led595_serializer.
// The bright signal exists only when LED595_PWM_EN is defined.
interface led595_serializer_if #(
    parameter int WIDTH = 16
`ifdef LED595_PWM_EN
  , parameter int PWM_BITS = 4
`endif
);
    logic [WIDTH-1:0]    pattern_in;
    logic                load;
`ifdef LED595_PWM_EN
    logic [PWM_BITS-1:0] bright;
`endif
    logic                busy;
    logic                done;
    logic                ser;
    logic                srclk;
    logic                rclk;
    logic                oe_n;

`ifdef LED595_PWM_EN
    modport master (output pattern_in, load, bright,
                    input  busy, done, ser, srclk, rclk, oe_n);
    modport slave  (input  pattern_in, load, bright,
                    output busy, done, ser, srclk, rclk, oe_n);
`else
    modport master (output pattern_in, load,
                    input  busy, done, ser, srclk, rclk, oe_n);
    modport slave  (input  pattern_in, load,
                    output busy, done, ser, srclk, rclk, oe_n);
`endif
endinterface

// File: rtl/led595_phase_timer.sv
// DIV-cycle phase counter; last marks the final cycle of each phase.
module led595_phase_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic last
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (clear || last) cnt <= '0;
        else                    cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/led595_serializer.sv
// Shifts a WIDTH-bit LED pattern into two chained 74HC595s, MSB first.
// Optional brightness PWM on oe_n is enabled by defining LED595_PWM_EN.
module led595_serializer
    import led595_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
`ifdef LED595_PWM_EN
  , parameter int PWM_BITS = DEF_PWM_BITS
`endif
) (
    input logic               clk,
    input logic               rst_n,
    led595_serializer_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] pend_data, pend_data_nx;
    logic [BW-1:0]    bitcnt, bitcnt_nx;
    logic             pend, pend_nx;
    logic             shown, shown_nx;
    logic             done_nx;
    logic             last;

    // Phase counter free-runs across back-to-back frames; held at 0 in IDLE.
    led595_phase_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .last  (last)
    );

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        bitcnt_nx    = bitcnt;
        pend_nx      = pend;
        pend_data_nx = pend_data;
        shown_nx     = shown;
        done_nx      = 1'b0;

        if (state != IDLE && bus.load) begin
            pend_nx      = 1'b1;
            pend_data_nx = bus.pattern_in;
        end

        case (state)
            IDLE: if (bus.load) begin
                shreg_nx  = bus.pattern_in;
                bitcnt_nx = '0;
                state_nx  = SH_LO;
            end
            SH_LO: if (last) state_nx = SH_HI;
            SH_HI: if (last) begin
                shreg_nx = shreg << 1;
                if (bitcnt == BW'(WIDTH - 1)) begin
                    bitcnt_nx = '0;
                    state_nx  = LT_HI;
                end else begin
                    bitcnt_nx = bitcnt + BW'(1);
                    state_nx  = SH_LO;
                end
            end
            LT_HI: if (last) state_nx = LT_LO;
            LT_LO: if (last) begin
                done_nx  = 1'b1;
                shown_nx = 1'b1;
                // a load in this very cycle is already folded into pend_nx
                if (pend_nx) begin
                    shreg_nx = pend_data_nx;
                    pend_nx  = 1'b0;
                    state_nx = SH_LO;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            pend_data <= '0;
            bitcnt    <= '0;
            pend      <= 1'b0;
            shown     <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            pend_data <= pend_data_nx;
            bitcnt    <= bitcnt_nx;
            pend      <= pend_nx;
            shown     <= shown_nx;
        end
    end

    // Pins are registered from next-state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.ser   <= 1'b0;
            bus.srclk <= 1'b0;
            bus.rclk  <= 1'b0;
        end else begin
            bus.busy  <= (state_nx != IDLE);
            bus.done  <= done_nx;
            bus.ser   <= shreg_nx[WIDTH-1];
            bus.srclk <= (state_nx == SH_HI);
            bus.rclk  <= (state_nx == LT_HI);
        end
    end

`ifdef LED595_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            bus.oe_n <= 1'b1;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            bus.oe_n <= !(shown && (pwm_cnt < bus.bright));
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.oe_n <= 1'b1;
        else        bus.oe_n <= !shown_nx;
    end
`endif
endmodule

// File: doc/led595_serializer.md
Name: led595_serializer

Overview:
- Downstream stage of the running-light generator: takes its 16-bit LED pattern and shifts it out to two daisy-chained 74HC595 shift registers driving the board LEDs.
- Frames are requested by a load pulse.
- Holds a one-deep pending buffer so pattern updates arriving mid-frame are not lost; only the newest survives.
- Owns SER/SRCLK/RCLK/OE_n pin timing; all pin outputs are registered.

Parameters:
- WIDTH, 16, bits per frame (pattern width, MSB shifted first)
- DIV, 4, clk cycles per half-period of srclk/rclk; legal range 1..255
- PWM_BITS, 4, brightness counter width (used only with LED595_PWM_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pattern_in  in  WIDTH  LED pattern to send
- load  in  1  1-cycle request to send pattern_in
- bright  in  PWM_BITS  brightness duty (present only with LED595_PWM_EN)
- busy  out  1  frame in progress
- done  out  1  1-cycle pulse after each frame's latch completes
- ser  out  1  serial data to 595
- srclk  out  1  595 shift clock
- rclk  out  1  595 storage/latch clock
- oe_n  out  1  595 output enable, active-low

Behaviour:
- Reset values: busy=0, done=0, ser=0, srclk=0, rclk=0, oe_n=1. State=IDLE; pending flag cleared; shown flag cleared.
- Reset asserted mid-frame aborts immediately. Outputs return to reset values. Pending data is discarded. oe_n returns to 1 until the next completed latch.
- States:
  - IDLE: srclk=rclk=0. load=1 captures pattern_in into shreg at that edge, then goes to SH_LO.
  - SH_LO (DIV cycles): ser=shreg[WIDTH-1], srclk=0.
  - SH_HI (DIV cycles): srclk=1, ser held. On exit, shreg shifts left by 1 and bitcnt increments. If bitcnt reaches WIDTH, go to LT_HI; otherwise go to SH_LO.
  - LT_HI (DIV cycles): rclk=1, srclk=0. LT_LO (DIV cycles): rclk=0.
  - On exit from LT_LO: done=1 for one cycle, shown flag set, then restart or go IDLE (see pending rules).
- Timing:
  - Frame length is exactly (2*WIDTH+2)*DIV cycles; default is 136.
  - If load is accepted at edge t0, busy=1 for cycles t0+1..t0+136 and done=1 in cycle t0+137.
- Pending rules:
  - load while busy stores pattern_in into pend_data and sets pend. A later load overwrites it; last one wins.
  - load in the final frame cycle counts as pending.
  - At frame end with pend set: the next frame starts directly from pend_data with no IDLE cycle. busy stays 1, done still pulses, pend is cleared.
  - load in the same cycle as done: accepted as a fresh start, as from IDLE.
- Phase counter counts 0..DIV-1. DIV=1 gives srclk at clk/2.
- ser changes only while srclk=0; it is never changed on the srclk rising edge.
- oe_n=1 until the first latch completes, so power-up garbage is never displayed.

Optional Feature:
- Macro: LED595_PWM_EN
- Defined:
  - bright port exists; a free-running PWM_BITS counter runs from reset.
  - oe_n=0 iff shown && pwm_cnt<bright.
  - bright=0 keeps the LEDs always dark; max bright gives (2^PWM_BITS-1)/2^PWM_BITS duty.
  - oe_n is registered.
- Undefined: no bright port; oe_n = !shown.

Decomposition:
- Package led595_pkg: state enum (IDLE, SH_LO, SH_HI, LT_HI, LT_LO), default WIDTH/DIV constants, and the frame-length function (2*WIDTH+2)*DIV.
- Sub-module led595_phase_timer: DIV-cycle phase counter with start/clear input and last-cycle strobe output.
- FSM, shift register, pending buffer and PWM live in the top.

Test Plan:
- Reset check: hold rst_n=0 → busy=0, done=0, ser=0, srclk=0, rclk=0, oe_n=1. Release with no load for 200 cycles → outputs unchanged.
- Single frame: WIDTH=16, DIV=4, load pattern 16'h0001 → 16 srclk rising edges and ser=1 only on the 16th edge. One rclk high pulse of 4 cycles. busy high for 136 cycles, done at t0+137, oe_n=0 from then on.
- Overwrite: load 16'h0001, then load 16'h0002 at t0+10 and 16'h0004 at t0+50 → exactly two frames, back-to-back (busy continuous for 272 cycles). The second frame carries 16'h0004. Two done pulses.
- Coincident load: load 16'h8000 in the cycle done=1 → new frame starts the next cycle, first ser bit=1, busy high 136 cycles.
- Reset mid-frame: assert rst_n=0 at t0+60 of a frame with a pending load → immediate reset values and no done pulse. After release, no frame starts without a new load.
- PWM (LED595_PWM_EN, PWM_BITS=4): after one frame, bright=4 → oe_n low 4 of every 16 cycles. bright=0 → oe_n constantly 1.
- DIV=1 corner: single frame takes 34 cycles; srclk toggles every cycle during shifting.
